// File: rtl/divider_32bit_seq.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, WIDTH-bit quotient and remainder.
// Define SIGNED_DIV_EN for two's-complement operands; otherwise the divider is purely unsigned.
module divider_32bit_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic             w_fits;
  logic [WIDTH-1:0] w_remNext;
  logic [WIDTH-1:0] w_quoNext;
  logic             w_last;
  logic [WIDTH-1:0] w_opA;
  logic [WIDTH-1:0] w_opB;
  logic [WIDTH-1:0] w_quoFinal;
  logic [WIDTH-1:0] w_remFinal;

  // The shifted partial remainder carries one extra bit so the compare never overflows.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_fits    = (w_shift >= {1'b0, r_divisor});
  assign w_remNext = w_fits ? WIDTH'(w_shift - {1'b0, r_divisor}) : w_shift[WIDTH-1:0];
  assign w_quoNext = {r_quo[WIDTH-2:0], w_fits};
  assign w_last    = (r_count == CNT_W'(WIDTH - 1));

`ifdef SIGNED_DIV_EN
  logic r_negQ;
  logic r_negR;

  assign w_opA      = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_opB      = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign w_quoFinal = r_negQ ? -w_quoNext : w_quoNext;
  assign w_remFinal = r_negR ? -w_remNext : w_remNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_negQ <= 1'b0;
      r_negR <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_negQ <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_negR <= dividend[WIDTH-1];
    end
  end
`else
  assign w_opA      = dividend;
  assign w_opB      = divisor;
  assign w_quoFinal = w_quoNext;
  assign w_remFinal = w_remNext;
`endif

  // A zero divisor skips the iterations and reports all-ones quotient with the dividend as remainder.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count   <= '0;
            r_divisor <= w_opB;
            if (divisor == '0) begin
              r_quo   <= '1;
              r_rem   <= dividend;
              r_dbz   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_quo   <= w_opA;
              r_rem   <= '0;
              r_dbz   <= 1'b0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_quo   <= w_quoFinal;
            r_rem   <= w_remFinal;
            r_state <= S_DONE;
          end else begin
            r_quo <= w_quoNext;
            r_rem <= w_remNext;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == S_CALC);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_32bit_seq.sv
// Scoreboard bench for divider_32bit_seq: stimulus pushes expected results, a monitor pops them on done.
// Signed vectors are exercised when SIGNED_DIV_EN is defined.
module tb_divider_32bit_seq;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
    int          startCycle;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divByZero;

  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  logic prevDone = 1'b0;
  exp_t sb[$];

  divider_32bit_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(divByZero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference result: SystemVerilog / and % plus the divide-by-zero and overflow rules.
  function automatic void modelDiv(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r, output logic dbz);
    dbz = (b == 32'd0);
    if (dbz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
`ifdef SIGNED_DIV_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // Monitor: every done must match the oldest expectation and last exactly one cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        checkOutput("donePulseWidth", {63'd0, prevDone}, 64'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedDone: got done=1, expected no pending division (cycle %0d)", cycle);
        end else begin
          e = sb.pop_front();
          checkOutput("quotient", {32'd0, quotient}, {32'd0, e.q});
          checkOutput("remainder", {32'd0, remainder}, {32'd0, e.r});
          checkOutput("divByZero", {63'd0, divByZero}, {63'd0, e.dbz});
          checkOutput("latency", 64'(cycle - e.startCycle), 64'(e.lat));
        end
      end
      prevDone = done;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                       input logic [31:0] r, input logic dbz, input int lat, input bit push);
    int   guard = 0;
    exp_t e;
    @(negedge clk);
    while ((busy || done) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy || done) begin
      checks++;
      errors++;
      $display("[TB] FAIL idleWait: got busy=%0b done=%0b, expected idle", busy, done);
      return;
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) begin
      e.q = q; e.r = r; e.dbz = dbz; e.lat = lat; e.startCycle = cycle;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (sb.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL doneTimeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    issue(v.a, v.b, v.q, v.r, v.dbz, v.lat, 1'b1);
    waitDrain();
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_busy"}, {63'd0, busy}, 64'd0);
    checkOutput({tag, "_done"}, {63'd0, done}, 64'd0);
    checkOutput({tag, "_quotient"}, {32'd0, quotient}, 64'd0);
    checkOutput({tag, "_remainder"}, {32'd0, remainder}, 64'd0);
    checkOutput({tag, "_divByZero"}, {63'd0, divByZero}, 64'd0);
  endtask

  initial begin
    vec_t vecs[$];
    logic [31:0] a, b, q, r;
    logic        dbz;

    start = 1'b1;
    dividend = 32'd100;
    divisor = 32'd7;
    repeat (2) @(negedge clk);
    checkIdleZero("reset");
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("postReset_busy", {63'd0, busy}, 64'd0);

`ifdef SIGNED_DIV_EN
    vecs.push_back('{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33});
    vecs.push_back('{32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33});
    vecs.push_back('{32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33});
    vecs.push_back('{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 33});
    vecs.push_back('{32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 33});
    vecs.push_back('{32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33});
    vecs.push_back('{32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1});
`else
    vecs.push_back('{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33});
    vecs.push_back('{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33});
    vecs.push_back('{32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33});
    vecs.push_back('{32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33});
    vecs.push_back('{32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0, 33});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33});
`endif
    vecs.push_back('{32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1});

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // A second start with new operands mid-operation must be ignored.
    issue(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33, 1'b1);
    repeat (9) @(negedge clk);
    dividend = 32'd77;
    divisor  = 32'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDrain();

    // Reset mid-operation: outputs clear and no done pulse may follow.
    issue(32'hDEAD_BEEF, 32'd5, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkIdleZero("midReset");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("midReset_stillIdle", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 100; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      if (b == 32'd0) b = 32'd1;
      modelDiv(a, b, q, r, dbz);
      issue(a, b, q, r, dbz, 33, 1'b1);
      waitDrain();
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
